reg_bank_arbiter: RTL

- Shares one small register bank (DEPTH words × WIDTH bits) between two requesters, port 0 and port 1.
- Each access uses a req/gnt/ack handshake. Arbitration is round-robin.
- The block sequences each write or read through a 3-state FSM.
- It sits between two bus-side masters and the register storage built from edge-triggered flops with asynchronous active-low reset.

---
 rtl/reg_bank_arbiter_pkg.sv | 13 +
 rtl/reg_bank_arbiter_if.sv | 30 +++
 rtl/reg_bank_arbiter_storage.sv | 50 +++++
 rtl/reg_bank_arbiter.sv | 126 ++++++++++++
 4 files changed

// File: rtl/reg_bank_arbiter_pkg.sv
// rtl/reg_bank_arbiter_pkg.sv - shared types for the two-port register bank arbiter
package reg_bank_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    ACK   = 2'b10
  } state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/reg_bank_arbiter_if.sv
// rtl/reg_bank_arbiter_if.sv - two-requester req/gnt/ack bus into the shared register bank
interface reg_bank_arbiter_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [WIDTH-1:0]  wdata0;
  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [WIDTH-1:0]  wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              ack0;
  logic              ack1;
  logic [WIDTH-1:0]  rdata;
  logic              busy;

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1,
    input  gnt0, gnt1, ack0, ack1, rdata, busy
  );

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1,
    output gnt0, gnt1, ack0, ack1, rdata, busy
  );
endinterface

// File: rtl/reg_bank_arbiter_storage.sv
// rtl/reg_bank_arbiter_storage.sv - DEPTH x WIDTH flop array with write-through read port
// Optional REG_BANK_PRESET_EN adds an async active-low Preset that fills the array with ones.
module reg_bank_storage #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              Clock,
  input  logic              Reset,
`ifdef REG_BANK_PRESET_EN
  input  logic              Preset,
`endif
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

`ifdef REG_BANK_PRESET_EN
  always_ff @(posedge Clock or negedge Reset or negedge Preset) begin
`else
  always_ff @(posedge Clock or negedge Reset) begin
`endif
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end
`ifdef REG_BANK_PRESET_EN
    else if (!Preset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '1;
    end
`endif
    else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (we_i && (addr_i == ADDR_W'(i))) mem_q[i] <= wdata_i;
      end
    end
  end

  // Addresses with no matching word fall through to zero, so out-of-range reads return 0
  // and out-of-range writes touch nothing.
  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr_i == ADDR_W'(i)) rdata_o = we_i ? wdata_i : mem_q[i];
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// rtl/reg_bank_arbiter.sv - round-robin arbiter sharing one register bank between two requesters
// Optional REG_BANK_PRESET_EN exposes the storage Preset input.
module reg_bank_arbiter
  import reg_bank_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic Clock,
  input  logic Reset,
`ifdef REG_BANK_PRESET_EN
  input  logic Preset,
`endif
  reg_bank_arbiter_if.slave bus
);

  state_e           state_q, state_d;
  logic             winner_q, winner_d;
  logic             ptr_q, ptr_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic             ack0_q, ack0_d, ack1_q, ack1_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;

  logic              w_req, w_we, mem_we;
  logic [ADDR_W-1:0] w_addr;
  logic [WIDTH-1:0]  w_wdata, mem_rdata;

  // The loser's inputs are never looked at: everything goes through the winner mux.
  assign w_req   = (winner_q == PORT1) ? bus.req1   : bus.req0;
  assign w_we    = (winner_q == PORT1) ? bus.we1    : bus.we0;
  assign w_addr  = (winner_q == PORT1) ? bus.addr1  : bus.addr0;
  assign w_wdata = (winner_q == PORT1) ? bus.wdata1 : bus.wdata0;
  assign mem_we  = (state_q == GRANT) && w_req && w_we;

  reg_bank_storage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_storage (
    .Clock   (Clock),
    .Reset   (Reset),
`ifdef REG_BANK_PRESET_EN
    .Preset  (Preset),
`endif
    .we_i    (mem_we),
    .addr_i  (w_addr),
    .wdata_i (w_wdata),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      winner_q <= PORT0;
      ptr_q    <= PORT0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      busy_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      ptr_q    <= ptr_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      busy_q   <= busy_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    ptr_d    = ptr_q;
    gnt0_d   = gnt0_q;
    gnt1_d   = gnt1_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          winner_d = (bus.req0 && bus.req1) ? ptr_q : (bus.req1 ? PORT1 : PORT0);
          state_d  = GRANT;
          gnt0_d   = (winner_d == PORT0);
          gnt1_d   = (winner_d == PORT1);
        end
      end
      GRANT: begin
        if (w_req) begin
          state_d = ACK;
          rdata_d = mem_rdata;
          ack0_d  = (winner_q == PORT0);
          ack1_d  = (winner_q == PORT1);
        end else begin
          // Abort leaves the pointer alone so the same port keeps its turn.
          state_d = IDLE;
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
        end
      end
      ACK: begin
        state_d = IDLE;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        ptr_d   = ~winner_q;
      end
      default: begin
        state_d = IDLE;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  assign bus.gnt0  = gnt0_q;
  assign bus.gnt1  = gnt1_q;
  assign bus.ack0  = ack0_q;
  assign bus.ack1  = ack1_q;
  assign bus.busy  = busy_q;
  assign bus.rdata = rdata_q;

endmodule
